// File: rtl/count_capture_fifo_pkg.sv
// Shared constants and helpers for count_capture_fifo and related event-capture blocks.
package count_capture_fifo_pkg;

   localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
   localparam string ARCH_VIRTEX5    = "VIRTEX5";
   localparam string ARCH_VIRTEX6    = "VIRTEX6";

   localparam int unsigned DROP_CNT_WIDTH = 16;

   function automatic int unsigned fifo_depth(input int unsigned depth_log2);
      return 32'(1) << depth_log2;
   endfunction

   function automatic int unsigned clog2_u(input int unsigned value);
      int unsigned bits;
      bits = 0;
      while ((32'(1) << bits) < value) bits = bits + 1;
      return bits;
   endfunction

endpackage

// File: rtl/count_capture_fifo_edge_detect_rise.sv
// Rising-edge detector: one-cycle pulse when sig goes 0->1; INIT sets the
// remembered level after reset so a level held through reset is not an edge.
module edge_detect_rise #(
   parameter bit INIT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise_c
);

   logic sig_d;

   always_ff @(posedge clk) begin
      if (rst) sig_d <= INIT;
      else     sig_d <= sig;
   end

   assign rise_c = sig & ~sig_d;

endmodule

// File: rtl/count_capture_fifo.sv
// Captures count_in on each rising edge of trig into a small FWFT FIFO read as a valid/ready stream.
// Optional drop counter output enabled by macro COUNT_CAPTURE_DROP_CNT_EN.
module count_capture_fifo
   import count_capture_fifo_pkg::*;
#(
   parameter string       ARCHITECTURE = "BEHAVIORAL",
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned DEPTH_LOG2   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] count_in,
   input  logic                  trig,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  full,
   output logic                  empty,
`ifdef COUNT_CAPTURE_DROP_CNT_EN
   output logic                  overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`else
   output logic                  overflow
`endif
);

   localparam int unsigned DEPTH = fifo_depth(DEPTH_LOG2);
   localparam int unsigned OCC_W = DEPTH_LOG2 + 1;

   // Vendor architectures map onto the behavioural implementation.
   if (ARCHITECTURE != ARCH_BEHAVIORAL) begin : g_arch_fallback
   end

   logic                  trig_rise_c;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [OCC_W-1:0]      occ;

   logic                  pop_c;
   logic                  push_c;
   logic                  drop_c;
   logic [OCC_W-1:0]      occ_next_c;
   logic [DEPTH_LOG2-1:0] rd_next_c;
   logic [DATA_WIDTH-1:0] head_next_c;

   edge_detect_rise #(.INIT(1'b1)) u_trig_edge (
      .clk    (clk),
      .rst    (rst),
      .sig    (trig),
      .rise_c (trig_rise_c)
   );

   // A capture into a full FIFO is only accepted when the head leaves on the same edge.
   always_comb begin
      pop_c       = out_valid & out_ready;
      push_c      = trig_rise_c & (~full | pop_c);
      drop_c      = trig_rise_c & full & ~pop_c;
      occ_next_c  = occ + OCC_W'(push_c) - OCC_W'(pop_c);
      rd_next_c   = rd_ptr + DEPTH_LOG2'(pop_c);
      head_next_c = out_data;
      if (push_c && (occ == OCC_W'(pop_c))) head_next_c = count_in;
      else if (occ_next_c != '0)            head_next_c = mem[rd_next_c];
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= count_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         full      <= 1'b0;
         empty     <= 1'b1;
      end else begin
         wr_ptr    <= wr_ptr + DEPTH_LOG2'(push_c);
         rd_ptr    <= rd_next_c;
         occ       <= occ_next_c;
         out_data  <= head_next_c;
         out_valid <= (occ_next_c != '0);
         full      <= (occ_next_c == OCC_W'(DEPTH));
         empty     <= (occ_next_c == '0);
      end
   end

`ifdef COUNT_CAPTURE_DROP_CNT_EN
   // Saturating, so once non-zero it never returns to zero and overflow stays sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (drop_c) begin
         overflow <= 1'b1;
         if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst)         overflow <= 1'b0;
      else if (drop_c) overflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_count_capture_fifo.sv
// Scoreboard bench for count_capture_fifo: queue-based reference model plus handshake monitor.
module tb_count_capture_fifo;

   localparam int unsigned DW    = 8;
   localparam int unsigned DL2   = 2;
   localparam int unsigned DEPTH = 1 << DL2;

   logic          clk;
   logic          rst;
   logic [DW-1:0] count_in;
   logic          trig;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          full;
   logic          empty;
   logic          overflow;
`ifdef COUNT_CAPTURE_DROP_CNT_EN
   logic [15:0]   drop_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [DW-1:0] mq [$];
   logic [DW-1:0] sb [$];
   logic          m_trig_prev = 1'b1;
   logic          m_ovf = 1'b0;
   int            m_drops = 0;
   bit            started = 0;

   count_capture_fifo #(
      .ARCHITECTURE ("BEHAVIORAL"),
      .DATA_WIDTH   (DW),
      .DEPTH_LOG2   (DL2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .count_in  (count_in),
      .trig      (trig),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .full      (full),
      .empty     (empty),
`ifdef COUNT_CAPTURE_DROP_CNT_EN
      .overflow  (overflow),
      .drop_cnt  (drop_cnt)
`else
      .overflow  (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: edge requests captured in order; pop when non-empty and ready; drop only if full with no pop.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         sb.delete();
         m_trig_prev = 1'b1;
         m_ovf       = 1'b0;
         m_drops     = 0;
         started     = 1;
      end else begin
         bit was_full;
         bit popped;
         was_full = (mq.size() == DEPTH);
         popped   = (mq.size() > 0) && out_ready;
         if (popped) void'(mq.pop_front());
         if (trig && !m_trig_prev) begin
            if (!was_full || popped) begin
               mq.push_back(count_in);
               sb.push_back(count_in);
            end else begin
               m_ovf = 1'b1;
               if (m_drops < 16'hFFFF) m_drops++;
            end
         end
         m_trig_prev = trig;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Monitor: flags against model occupancy; head data against scoreboard on each handshake.
   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", int'(out_valid), int'(mq.size() > 0));
         chk("empty",     int'(empty),     int'(mq.size() == 0));
         chk("full",      int'(full),      int'(mq.size() == DEPTH));
         chk("overflow",  int'(overflow),  int'(m_ovf));
`ifdef COUNT_CAPTURE_DROP_CNT_EN
         chk("drop_cnt",  int'(drop_cnt),  m_drops);
`endif
         if (out_valid && out_ready && !rst) begin
            if (sb.size() == 0) begin
               chk("unexpected_pop", 1, 0);
            end else begin
               logic [DW-1:0] e;
               e = sb.pop_front();
               chk("out_data", int'(out_data), int'(e));
            end
         end
      end
   end

   task automatic step(input logic t, input logic [DW-1:0] c, input logic r, input logic rs);
      trig      = t;
      count_in  = c;
      out_ready = r;
      rst       = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic [DW-1:0] c, input logic r);
      step(1'b1, c, r, 1'b0);
      step(1'b0, c, r, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] cnt;
      // Trig held high through reset and after release: no capture
      for (int i = 0; i < 3; i++) step(1'b1, 8'd7, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 8'd8, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      // Single pulse with ready high
      pulse(8'h2A, 1'b1);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      // Trig held high for ten cycles with a running count
      for (int i = 0; i < 10; i++) step(1'b1, DW'(5 + i), 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      // Fill beyond depth with no reads, then drain
      pulse(8'd10, 1'b0);
      pulse(8'd20, 1'b0);
      pulse(8'd30, 1'b0);
      pulse(8'd40, 1'b0);
      pulse(8'd50, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
      // Full FIFO, capture and pop on the same edge
      pulse(8'd61, 1'b0);
      pulse(8'd62, 1'b0);
      pulse(8'd63, 1'b0);
      pulse(8'd64, 1'b0);
      step(1'b1, 8'd99, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
      // Three queued then reset, with a request coinciding with reset
      pulse(8'd71, 1'b0);
      pulse(8'd72, 1'b0);
      pulse(8'd73, 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b0);
      step(1'b1, 8'd74, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
`ifdef COUNT_CAPTURE_DROP_CNT_EN
      // Seven pulses into depth four: three drops, then reset clears the counter
      for (int i = 0; i < 7; i++) pulse(DW'(100 + i), 1'b0);
      step(1'b0, 8'd0, 1'b0, 1'b1);
      step(1'b0, 8'd0, 1'b0, 1'b0);
`endif
      // Randomised traffic with a free-running count
      cnt = DW'($urandom);
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 99) < 40), cnt, 1'($urandom_range(0, 99) < 45),
              1'($urandom_range(0, 999) < 4));
         cnt = cnt + DW'(1);
      end
      for (int i = 0; i < 12; i++) step(1'b0, 8'd0, 1'b1, 1'b0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
